// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator with a 2-entry elastic output buffer (valid/ready both sides).
// Optional: define IMMGEN_ILLEGAL_CNT_EN to add the saturating illegal_cnt port.
module imm_gen_pipe #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
`ifdef IMMGEN_ILLEGAL_CNT_EN
  output logic [15:0]     illegal_cnt,
`endif
  output logic            out_illegal
);

  localparam int unsigned FMT_W = 3;
  localparam int unsigned CNT_W = 2;

  localparam logic [FMT_W-1:0] FMT_NONE = 3'd0;
  localparam logic [FMT_W-1:0] FMT_I    = 3'd1;
  localparam logic [FMT_W-1:0] FMT_S    = 3'd2;
  localparam logic [FMT_W-1:0] FMT_B    = 3'd3;
  localparam logic [FMT_W-1:0] FMT_U    = 3'd4;
  localparam logic [FMT_W-1:0] FMT_J    = 3'd5;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [31:0]      instr;
    logic [XLEN-1:0]  imm;
    logic [FMT_W-1:0] fmt;
    logic             illegal;
  } entry_t;

  entry_t           dec;
  entry_t           head_q;
  entry_t           tail_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_nxt;
  logic             push;
  logic             pop;

  // Opcode classification and sign-extended immediate; any unlisted opcode
  // (including words whose low two bits are not 11) is illegal.
  always_comb begin
    dec       = '0;
    dec.instr = in_instr;
    case (in_instr[6:0])
      OP_IMM, OP_LOAD, OP_JALR: begin
        dec.fmt = FMT_I;
        dec.imm = XLEN'($signed(in_instr[31:20]));
      end
      OP_STORE: begin
        dec.fmt = FMT_S;
        dec.imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      end
      OP_BRANCH: begin
        dec.fmt = FMT_B;
        dec.imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                 in_instr[11:8], 1'b0}));
      end
      OP_JAL: begin
        dec.fmt = FMT_J;
        dec.imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                 in_instr[30:21], 1'b0}));
      end
      OP_LUI, OP_AUIPC: begin
        dec.fmt = FMT_U;
        dec.imm = XLEN'($signed({in_instr[31:12], 12'b0}));
      end
      OP_REG, OP_FENCE, OP_SYSTEM: begin
        dec.fmt = FMT_NONE;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

  // Handshakes use only registered ready/valid, so out_ready never reaches in_ready.
  always_comb begin
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    count_nxt = count_q;
    case ({push, pop})
      2'b10:   count_nxt = count_q + CNT_W'(1);
      2'b01:   count_nxt = count_q - CNT_W'(1);
      default: count_nxt = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      head_q    <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else if (flush) begin
      count_q   <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      count_q   <= count_nxt;
      out_valid <= (count_nxt != CNT_W'(0));
      in_ready  <= (count_nxt != CNT_W'(2));
      // New word lands in head when the buffer is or becomes empty, otherwise in tail.
      if (push && ((count_q == CNT_W'(0)) || (pop && (count_q == CNT_W'(1))))) begin
        head_q <= dec;
      end else if (pop && (count_q == CNT_W'(2))) begin
        head_q <= tail_q;
      end
      if (push && !pop && (count_q == CNT_W'(1))) begin
        tail_q <= dec;
      end
    end
  end

  assign out_instr   = head_q.instr;
  assign out_imm     = head_q.imm;
  assign out_fmt     = head_q.fmt;
  assign out_illegal = head_q.illegal;

`ifdef IMMGEN_ILLEGAL_CNT_EN
  // Counts accepted illegal words, even those later dropped by flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_cnt <= '0;
    end else if (push && dec.illegal && (illegal_cnt != 16'hFFFF)) begin
      illegal_cnt <= illegal_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus and are
// compared each cycle against a queue-based reference; IMMGEN_ILLEGAL_CNT_EN also checks the counter.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_instr32, out_imm32;
  logic [2:0]  out_fmt32;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [31:0] out_instr64;
  logic [63:0] out_imm64;
  logic [2:0]  out_fmt64;
`ifdef IMMGEN_ILLEGAL_CNT_EN
  logic [15:0] illegal_cnt32, illegal_cnt64;
  logic [15:0] cnt_m = '0;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] q[$];
  bit after_rst = 1'b0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .out_valid(out_valid32), .out_ready(out_ready),
    .out_instr(out_instr32), .out_imm(out_imm32), .out_fmt(out_fmt32),
`ifdef IMMGEN_ILLEGAL_CNT_EN
    .illegal_cnt(illegal_cnt32),
`endif
    .out_illegal(out_illegal32)
  );

  imm_gen_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .out_valid(out_valid64), .out_ready(out_ready),
    .out_instr(out_instr64), .out_imm(out_imm64), .out_fmt(out_fmt64),
`ifdef IMMGEN_ILLEGAL_CNT_EN
    .illegal_cnt(illegal_cnt64),
`endif
    .out_illegal(out_illegal64)
  );

  // Reference decode: immediate value as a signed integer built from the field layout.
  function automatic void ref_dec(input logic [31:0] w, output logic [63:0] imm,
                                  output logic [2:0] fmt, output logic ill);
    longint v;
    v = 0; fmt = 3'd0; ill = 1'b0;
    case (w[6:0])
      7'h13, 7'h03, 7'h67: begin
        fmt = 3'd1; v = longint'(w[31:20]);
        if (w[31]) v = v - 4096;
      end
      7'h23: begin
        fmt = 3'd2; v = longint'({w[31:25], w[11:7]});
        if (w[31]) v = v - 4096;
      end
      7'h63: begin
        fmt = 3'd3; v = longint'({w[31], w[7], w[30:25], w[11:8]}) * 2;
        if (w[31]) v = v - 8192;
      end
      7'h6F: begin
        fmt = 3'd5; v = longint'({w[31], w[19:12], w[20], w[30:21]}) * 2;
        if (w[31]) v = v - 2097152;
      end
      7'h37, 7'h17: begin
        fmt = 3'd4; v = longint'(w[31:12]) * 4096;
        if (w[31]) v = v - 64'sd4294967296;
      end
      7'h33, 7'h0F, 7'h73: fmt = 3'd0;
      default: ill = 1'b1;
    endcase
    imm = 64'(v);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Compare both DUTs against the reference every cycle.
  task automatic check_cycle();
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    chk("in_ready32", 64'(in_ready32), 64'(q.size() != 2));
    chk("in_ready64", 64'(in_ready64), 64'(q.size() != 2));
    chk("out_valid32", 64'(out_valid32), 64'(q.size() != 0));
    chk("out_valid64", 64'(out_valid64), 64'(q.size() != 0));
    if (q.size() != 0) begin
      ref_dec(q[0], imm, fmt, ill);
      chk("instr32", 64'(out_instr32), 64'(q[0]));
      chk("instr64", 64'(out_instr64), 64'(q[0]));
      chk("imm32", 64'(out_imm32), 64'(imm[31:0]));
      chk("imm64", out_imm64, imm);
      chk("fmt32", 64'(out_fmt32), 64'(fmt));
      chk("fmt64", 64'(out_fmt64), 64'(fmt));
      chk("illegal32", 64'(out_illegal32), 64'(ill));
      chk("illegal64", 64'(out_illegal64), 64'(ill));
    end else if (after_rst) begin
      chk("rst_out32", {out_instr32, out_imm32}, 64'd0);
      chk("rst_out64", 64'(out_instr64) | out_imm64, 64'd0);
      chk("rst_flags", 64'({out_fmt32, out_illegal32, out_fmt64, out_illegal64}), 64'd0);
    end
`ifdef IMMGEN_ILLEGAL_CNT_EN
    chk("illegal_cnt32", 64'(illegal_cnt32), 64'(cnt_m));
    chk("illegal_cnt64", 64'(illegal_cnt64), 64'(cnt_m));
`endif
  endtask

  // One clock: update the reference with the pre-edge inputs, then check at the falling edge.
  task automatic tick();
    bit         do_push, do_pop;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    @(posedge clk);
    do_push = in_valid && (q.size() < 2);
    do_pop  = (q.size() > 0) && out_ready;
    ref_dec(in_instr, imm, fmt, ill);
    if (rst) begin
      q.delete();
      after_rst = 1'b1;
`ifdef IMMGEN_ILLEGAL_CNT_EN
      cnt_m = '0;
`endif
    end else begin
      after_rst = 1'b0;
`ifdef IMMGEN_ILLEGAL_CNT_EN
      if (do_push && ill && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
`endif
      if (flush) q.delete();
      else begin
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(in_instr);
      end
    end
    @(negedge clk);
    check_cycle();
  endtask

  task automatic drive(input bit v, input logic [31:0] w, input bit ordy,
                       input bit fl = 1'b0, input bit r = 1'b0);
    in_valid = v; in_instr = w; out_ready = ordy; flush = fl; rst = r;
    tick();
  endtask

  localparam logic [31:0] WA = 32'h00100093;
  localparam logic [31:0] WB = 32'h00208133;
  localparam logic [31:0] WC = 32'h0040A183;

  logic [31:0] stream [14] = '{32'h00000013, 32'hFFDFF06F, 32'h7FF00013, 32'h80000013,
                               32'h800000E7, 32'h7E000FA3, 32'h80000063, 32'h00000017,
                               32'h0000000F, 32'h00000073, 32'hFFF00090, 32'h0000000B,
                               32'h7FFFF06F, 32'h12345037};

  initial begin
    int idx;
    drive(0, 32'h0, 1, 0, 1);
    drive(0, 32'h0, 1, 0, 1);
    chk("reset_valid", 64'(out_valid32), 64'd0);

    // addi x1,x0,-1
    drive(1, 32'hFFF00093, 1);
    chk("t1_imm", 64'(out_imm32), 64'hFFFFFFFF);
    chk("t1_fmt", 64'(out_fmt32), 64'd1);
    drive(0, 32'h0, 1);

    // sw then beq back to back
    drive(1, 32'hFE112E23, 1);
    chk("t2_sw_imm", 64'(out_imm32), 64'hFFFFFFFC);
    chk("t2_sw_fmt", 64'(out_fmt32), 64'd2);
    drive(1, 32'hFE000CE3, 1);
    chk("t2_beq_imm", 64'(out_imm32), 64'hFFFFFFF8);
    chk("t2_beq_fmt", 64'(out_fmt32), 64'd3);
    drive(0, 32'h0, 1);

    // stall with three offered words, then release
    drive(1, WA, 0);
    drive(1, WB, 0);
    chk("t3_full", 64'(in_ready32), 64'd0);
    drive(1, WC, 0);
    chk("t3_hold_a", 64'(out_instr32), 64'(WA));
    drive(1, WC, 1);
    chk("t3_b", 64'(out_instr32), 64'(WB));
    drive(1, WC, 1);
    chk("t3_c", 64'(out_instr32), 64'(WC));
    drive(0, 32'h0, 1);
    chk("t3_empty", 64'(out_valid32), 64'd0);

    // flush while full with a concurrent offer
    drive(1, WA, 0);
    drive(1, WB, 0);
    drive(1, WC, 0, 1);
    chk("t4_flush", 64'(out_valid32), 64'd0);
    drive(0, 32'h0, 1);
    drive(1, WA, 0);
    drive(1, WB, 0);
    drive(1, WC, 0, 0, 1);
    chk("t4_rst_imm", out_imm64, 64'd0);

    // illegal words
    drive(1, 32'h00000000, 1);
    chk("t5_ill0", 64'(out_illegal32), 64'd1);
    drive(1, 32'h0000007F, 1);
    chk("t5_ill1", 64'({out_illegal32, out_fmt32}), 64'h8);
    drive(0, 32'h0, 1);
`ifdef IMMGEN_ILLEGAL_CNT_EN
    chk("t5_cnt", 64'(illegal_cnt32), 64'd2);
    drive(0, 32'h0, 1, 1);
    chk("t5_cnt_flush", 64'(illegal_cnt64), 64'd2);
`endif

    // U and J at both widths
    drive(1, 32'h800002B7, 1);
    chk("t6_lui64", out_imm64, 64'hFFFFFFFF80000000);
    chk("t6_lui32", 64'(out_imm32), 64'h80000000);
    chk("t6_fmt", 64'(out_fmt64), 64'd4);
    drive(1, 32'h0000006F, 1);
    chk("t6_jal_imm", out_imm64, 64'd0);
    chk("t6_jal_fmt", 64'(out_fmt64), 64'd5);
    drive(0, 32'h0, 1);

    // mixed stream with intermittent stalls and gaps, bounded cycle budget
    idx = 0;
    for (int cyc = 0; cyc < 200 && idx < 14; cyc++) begin
      bit v;
      v = (cyc % 4) != 3;
      if (v && q.size() < 2) begin
        drive(1, stream[idx], (cyc % 3) != 0);
        idx++;
      end else begin
        drive(v, stream[idx], (cyc % 3) != 0);
      end
    end
    chk("stream_done", 64'(idx), 64'd14);
    for (int k = 0; k < 4; k++) drive(0, 32'h0, 1);
    chk("drained", 64'(out_valid64), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
